// File: rtl/vector_processing_block.sv
// Multi-cycle SIMD block: fetch/exec over a private vector register file, lane-wise ALU, vector load/store.
// ALU/NOP retire in 2 cycles; load/store requests are held stable until load_valid / write_ready.
module vector_processing_block #(
    parameter int LANES    = 16,
    parameter int LANE_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic [ADDR_W-1:0]        instr_addr,
    input  logic [31:0]              instr_data,
    output logic [ADDR_W-1:0]        load_addr,
    output logic                     load_ctrl,
    input  logic                     load_valid,
    input  logic [LANES*LANE_W-1:0]  load_data,
    output logic [ADDR_W-1:0]        write_addr,
    output logic [LANES*LANE_W-1:0]  write_data,
    output logic                     write_ctrl,
    input  logic                     write_ready,
    output logic                     busy,
    output logic                     halted,
    output logic                     error
);
    localparam int VW = LANES * LANE_W;
    localparam int RI = $clog2(NUM_REGS);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_MUL   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_STORE = 8'h10;
    localparam logic [7:0] OP_LOAD  = 8'h20;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_EXEC, ST_LOAD_WAIT, ST_STORE_WAIT, ST_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic                error_q, error_d;
    logic                load_ctrl_q, load_ctrl_d;
    logic                write_ctrl_q, write_ctrl_d;
    logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
    logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
    logic [VW-1:0]       write_data_q, write_data_d;
    logic [VW-1:0]       regs_q [NUM_REGS];

    logic                reg_we;
    logic [VW-1:0]       reg_wdata;
    logic [VW-1:0]       alu_res;
    logic [7:0]          opcode;
    logic [RI-1:0]       rd_idx, ra_idx, rb_idx;
    logic [ADDR_W-1:0]   op_addr;
    logic [ADDR_W-1:0]   pc_inc;

    assign opcode  = ir_q[31:24];
    assign rd_idx  = ir_q[16 +: RI];
    assign ra_idx  = ir_q[8 +: RI];
    assign rb_idx  = ir_q[0 +: RI];
    assign op_addr = ADDR_W'(ir_q[15:0]);
    assign pc_inc  = pc_q + ADDR_W'(1);

    // Per-lane arithmetic: carries/borrows never cross lane boundaries.
    always_comb begin
        alu_res = '0;
        for (int i = 0; i < LANES; i++) begin
            case (opcode)
                OP_ADD:  alu_res[i*LANE_W +: LANE_W] = regs_q[ra_idx][i*LANE_W +: LANE_W]
                                                     + regs_q[rb_idx][i*LANE_W +: LANE_W];
                OP_MUL:  alu_res[i*LANE_W +: LANE_W] = regs_q[ra_idx][i*LANE_W +: LANE_W]
                                                     * regs_q[rb_idx][i*LANE_W +: LANE_W];
                OP_SUB:  alu_res[i*LANE_W +: LANE_W] = regs_q[ra_idx][i*LANE_W +: LANE_W]
                                                     - regs_q[rb_idx][i*LANE_W +: LANE_W];
                default: alu_res[i*LANE_W +: LANE_W] = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            error_q      <= 1'b0;
            load_ctrl_q  <= 1'b0;
            write_ctrl_q <= 1'b0;
            load_addr_q  <= '0;
            write_addr_q <= '0;
            write_data_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            error_q      <= error_d;
            load_ctrl_q  <= load_ctrl_d;
            write_ctrl_q <= write_ctrl_d;
            load_addr_q  <= load_addr_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            if (reg_we) regs_q[rd_idx] <= reg_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        error_d      = error_q;
        load_ctrl_d  = load_ctrl_q;
        write_ctrl_d = write_ctrl_q;
        load_addr_d  = load_addr_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        reg_we       = 1'b0;
        reg_wdata    = alu_res;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    error_d = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d    = instr_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_NOP: begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                    OP_ADD, OP_MUL, OP_SUB: begin
                        reg_we  = 1'b1;
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                    OP_LOAD: begin
                        load_addr_d = op_addr;
                        load_ctrl_d = 1'b1;
                        state_d     = ST_LOAD_WAIT;
                    end
                    OP_STORE: begin
                        write_addr_d = op_addr;
                        write_data_d = regs_q[rd_idx];
                        write_ctrl_d = 1'b1;
                        state_d      = ST_STORE_WAIT;
                    end
                    OP_HALT: state_d = ST_HALT;
                    default: begin
                        error_d = 1'b1;
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_LOAD_WAIT: begin
                if (load_valid) begin
                    reg_we      = 1'b1;
                    reg_wdata   = load_data;
                    load_ctrl_d = 1'b0;
                    pc_d        = pc_inc;
                    state_d     = ST_FETCH;
                end
            end
            ST_STORE_WAIT: begin
                if (write_ready) begin
                    write_ctrl_d = 1'b0;
                    pc_d         = pc_inc;
                    state_d      = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted     = (state_q == ST_HALT);
        error      = error_q;
        instr_addr = pc_q;
        load_addr  = load_addr_q;
        load_ctrl  = load_ctrl_q;
        write_addr = write_addr_q;
        write_data = write_data_q;
        write_ctrl = write_ctrl_q;
    end
endmodule

// File: tb/tb_vector_processing_block.sv
// Directed programs on a default-size instance plus a 4x8-bit instance; memory writes checked against a scoreboard.
module tb_vector_processing_block;
    typedef struct packed {
        logic [15:0]  addr;
        logic [511:0] data;
    } wr_t;

    logic         clock = 1'b0;
    logic         reset, start;
    logic [15:0]  instr_addr, load_addr, write_addr;
    logic [31:0]  instr_data;
    logic         load_ctrl, load_valid, write_ctrl, write_ready, busy, halted, error;
    logic [511:0] load_data, write_data;
    logic [31:0]  imem [64];
    logic [511:0] mem [32];

    logic         s_reset, s_start;
    logic [15:0]  s_instr_addr, s_load_addr, s_write_addr;
    logic [31:0]  s_instr_data, s_load_data, s_write_data;
    logic         s_load_ctrl, s_load_valid, s_write_ctrl, s_write_ready, s_busy, s_halted, s_error;
    logic [31:0]  s_imem [16];
    logic [31:0]  s_mem [4];

    int           total = 0;
    int           bad = 0;
    wr_t          exp_q[$];
    logic [15:0]  first_ld_addr;
    logic         ld_seen;

    always #5 clock = ~clock;

    assign instr_data    = imem[instr_addr[5:0]];
    assign s_instr_data  = s_imem[s_instr_addr[3:0]];
    assign s_load_data   = s_mem[s_load_addr[1:0]];
    assign s_load_valid  = 1'b1;
    assign s_write_ready = 1'b1;

    vector_processing_block dut (
        .clock(clock), .reset(reset), .start(start),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .load_addr(load_addr), .load_ctrl(load_ctrl), .load_valid(load_valid), .load_data(load_data),
        .write_addr(write_addr), .write_data(write_data), .write_ctrl(write_ctrl), .write_ready(write_ready),
        .busy(busy), .halted(halted), .error(error)
    );

    vector_processing_block #(.LANES(4), .LANE_W(8), .NUM_REGS(4), .ADDR_W(16)) dut_small (
        .clock(clock), .reset(s_reset), .start(s_start),
        .instr_addr(s_instr_addr), .instr_data(s_instr_data),
        .load_addr(s_load_addr), .load_ctrl(s_load_ctrl), .load_valid(s_load_valid), .load_data(s_load_data),
        .write_addr(s_write_addr), .write_data(s_write_data), .write_ctrl(s_write_ctrl), .write_ready(s_write_ready),
        .busy(s_busy), .halted(s_halted), .error(s_error)
    );

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] r, input logic [15:0] a);
        return {op, r, a};
    endfunction

    function automatic logic [31:0] alu(input logic [7:0] op, input logic [7:0] rd,
                                        input logic [7:0] ra, input logic [7:0] rb);
        return {op, rd, ra, rb};
    endfunction

    function automatic logic [511:0] splat2(input logic [31:0] even, input logic [31:0] odd);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = (i % 2 == 1) ? odd : even;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [511:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Memory responder: answers each request after a fixed delay, measures request hold time and stability.
    task automatic run_prog(input int ld_dly, input int st_dly, input int budget);
        int          ld_wait, st_wait, ld_hi, st_hi;
        logic [15:0] ref_addr, ref_pc;
        logic [511:0] ref_data;
        logic        steady;
        wr_t         e;
        ld_wait = 0; st_wait = 0; ld_hi = 0; st_hi = 0;
        ref_addr = '0; ref_pc = '0; ref_data = '0; steady = 1'b1;
        for (int cyc = 0; cyc < budget && !halted; cyc++) begin
            @(negedge clock);
            load_valid  = 1'b0;
            write_ready = 1'b0;
            if (load_ctrl) begin
                if (ld_hi == 0) begin
                    ref_addr = load_addr;
                    ref_pc   = instr_addr;
                    steady   = 1'b1;
                    if (!ld_seen) begin
                        first_ld_addr = load_addr;
                        ld_seen       = 1'b1;
                    end
                end else if (load_addr !== ref_addr || instr_addr !== ref_pc) begin
                    steady = 1'b0;
                end
                ld_hi++;
                if (ld_wait == ld_dly) begin
                    load_data  = mem[load_addr[4:0]];
                    load_valid = 1'b1;
                    ld_wait    = 0;
                    chk("ld_stable", steady, 1);
                end else begin
                    ld_wait++;
                end
            end else if (ld_hi != 0) begin
                chk("ld_hold", ld_hi, ld_dly + 1);
                ld_hi = 0;
            end
            if (write_ctrl) begin
                if (st_hi == 0) begin
                    ref_addr = write_addr;
                    ref_pc   = instr_addr;
                    ref_data = write_data;
                    steady   = 1'b1;
                end else if (write_addr !== ref_addr || instr_addr !== ref_pc || write_data !== ref_data) begin
                    steady = 1'b0;
                end
                st_hi++;
                if (st_wait == st_dly) begin
                    write_ready = 1'b1;
                    st_wait     = 0;
                    chk("wr_stable", steady, 1);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    chk("wr_addr", write_addr, e.addr);
                    chk("wr_data", write_data, e.data);
                end else begin
                    st_wait++;
                end
            end else if (st_hi != 0) begin
                chk("wr_hold", st_hi, st_dly + 1);
                st_hi = 0;
            end
        end
        load_valid  = 1'b0;
        write_ready = 1'b0;
        chk("halt_reached", halted, 1);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s_writes;
        logic [15:0] s_wa;
        logic [31:0] s_wd;

        reset = 1'b1; start = 1'b0; load_valid = 1'b0; write_ready = 1'b0; load_data = '0;
        s_reset = 1'b1; s_start = 1'b0;
        ld_seen = 1'b0; first_ld_addr = 'x;
        clear_imem();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) s_imem[i] = 32'hFF00_0000;
        repeat (2) @(negedge clock);
        reset = 1'b0; s_reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_error", error, 0);
        chk("rst_load_ctrl", load_ctrl, 0);
        chk("rst_write_ctrl", write_ctrl, 0);
        chk("rst_load_addr", load_addr, 0);
        chk("rst_write_addr", write_addr, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_pc", instr_addr, 0);

        // Main program, no back-pressure: 3*5+7 = 22 per lane.
        mem[0] = splat2(3, 3); mem[1] = splat2(5, 5); mem[2] = splat2(7, 7);
        imem[0] = ins(8'h20, 8'd0, 16'd0);
        imem[1] = ins(8'h20, 8'd1, 16'd1);
        imem[2] = ins(8'h20, 8'd2, 16'd2);
        imem[3] = alu(8'h02, 8'd3, 8'd0, 8'd1);
        imem[4] = alu(8'h01, 8'd4, 8'd3, 8'd2);
        imem[5] = ins(8'h10, 8'd4, 16'd1);
        imem[6] = 32'hFF00_0000;
        push_wr(16'd1, splat2(22, 22));
        pulse_start();
        run_prog(0, 0, 300);
        chk("first_load_addr", first_ld_addr, 0);
        chk("main_halted", halted, 1);
        chk("main_error", error, 0);
        chk("main_busy", busy, 0);
        chk("main_halt_pc", instr_addr, 6);

        // Same program with 5-cycle handshake delays; restart from HALT.
        push_wr(16'd1, splat2(22, 22));
        pulse_start();
        run_prog(5, 5, 600);
        chk("delay_error", error, 0);

        // Lane wrap-around without cross-lane carry, and same-register operands.
        mem[0] = splat2(32'hFFFF_FFFF, 5); mem[1] = splat2(1, 1);
        mem[3] = splat2(32'h0001_0000, 3); mem[4] = splat2(0, 9);
        clear_imem();
        imem[0]  = ins(8'h20, 8'd0, 16'd0);
        imem[1]  = ins(8'h20, 8'd1, 16'd1);
        imem[2]  = alu(8'h01, 8'd2, 8'd0, 8'd1);
        imem[3]  = ins(8'h10, 8'd2, 16'd10);
        imem[4]  = ins(8'h20, 8'd5, 16'd4);
        imem[5]  = alu(8'h03, 8'd6, 8'd5, 8'd1);
        imem[6]  = ins(8'h10, 8'd6, 16'd11);
        imem[7]  = ins(8'h20, 8'd7, 16'd3);
        imem[8]  = alu(8'h02, 8'd8, 8'd7, 8'd7);
        imem[9]  = ins(8'h10, 8'd8, 16'd12);
        imem[10] = alu(8'h01, 8'd1, 8'd1, 8'd1);
        imem[11] = ins(8'h10, 8'd1, 16'd13);
        push_wr(16'd10, splat2(0, 6));
        push_wr(16'd11, splat2(32'hFFFF_FFFF, 8));
        push_wr(16'd12, splat2(0, 9));
        push_wr(16'd13, splat2(2, 2));
        pulse_start();
        run_prog(1, 2, 600);
        chk("wrap_halt_pc", instr_addr, 12);

        // Illegal opcode at PC 3; PC 0 also proves r8 survived the HALT.
        clear_imem();
        imem[0] = ins(8'h10, 8'd8, 16'd14);
        imem[1] = 32'h0000_0000;
        imem[2] = 32'h0000_0000;
        imem[3] = 32'h7E00_0000;
        push_wr(16'd14, splat2(0, 9));
        pulse_start();
        run_prog(0, 0, 100);
        chk("ill_halted", halted, 1);
        chk("ill_error", error, 1);
        chk("ill_pc", instr_addr, 3);
        push_wr(16'd14, splat2(0, 9));
        pulse_start();
        chk("restart_error", error, 0);
        chk("restart_pc", instr_addr, 0);
        chk("restart_busy", busy, 1);
        run_prog(0, 0, 100);
        chk("ill2_error", error, 1);

        // Reset while a load is outstanding; the late load_valid must not land anywhere.
        clear_imem();
        mem[5] = splat2(32'hAAAA_AAAA, 32'h5555_5555);
        imem[0] = ins(8'h20, 8'd8, 16'd5);
        pulse_start();
        for (int i = 0; i < 20 && !load_ctrl; i++) @(negedge clock);
        chk("rst_ld_req_seen", load_ctrl, 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_load_ctrl", load_ctrl, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_load_addr", load_addr, 0);
        load_data  = mem[5];
        load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        imem[0] = ins(8'h10, 8'd8, 16'd20);
        push_wr(16'd20, '0);
        pulse_start();
        run_prog(0, 0, 100);

        // Small configuration: rd field 0x05 aliases to r1; byte lanes wrap.
        s_mem[0] = {4{8'hF0}};
        s_mem[1] = {4{8'h20}};
        s_imem[0] = ins(8'h20, 8'h00, 16'd0);
        s_imem[1] = ins(8'h20, 8'h01, 16'd1);
        s_imem[2] = alu(8'h01, 8'h05, 8'h00, 8'h01);
        s_imem[3] = ins(8'h10, 8'h01, 16'd3);
        s_writes = 0; s_wa = '0; s_wd = '0;
        @(negedge clock);
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        for (int i = 0; i < 100 && !s_halted; i++) begin
            @(negedge clock);
            if (s_write_ctrl) begin
                s_writes++;
                s_wa = s_write_addr;
                s_wd = s_write_data;
            end
        end
        chk("small_halted", s_halted, 1);
        chk("small_error", s_error, 0);
        chk("small_writes", s_writes, 1);
        chk("small_wr_addr", s_wa, 3);
        chk("small_wr_data", s_wd, 32'h1010_1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
